// File: rtl/complex_fu_sched_pkg.sv
// Shared definitions for the complex execution unit scheduler: widths, opcodes,
// op-class and FSM enums, the short-pipe stage record and opcode-class decode.
package complex_fu_sched_pkg;

  localparam int SIZE_DATA         = 32;
  localparam int SIZE_OPCODE_I     = 8;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int EXECUTION_FLAGS   = 6;
  localparam int SIZE_IMMEDIATE    = 16;

  localparam logic [SIZE_OPCODE_I-1:0] OPC_SYSCALL = 8'h01;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_MULT_L  = 8'h10;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_MULT_H  = 8'h11;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_MULTU_L = 8'h12;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_MULTU_H = 8'h13;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_DIV_L   = 8'h14;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_DIV_H   = 8'h15;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_DIVU_L  = 8'h16;
  localparam logic [SIZE_OPCODE_I-1:0] OPC_DIVU_H  = 8'h17;

  typedef enum logic {OP_SHORT, OP_DIV} op_class_e;
  typedef enum logic {IDLE, DIV_BUSY} sched_state_e;

  typedef struct packed {
    logic                         valid;
    logic [2*SIZE_DATA-1:0]       result;
    logic [EXECUTION_FLAGS-1:0]   flags;
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
  } pipe_stage_t;

  // Anything not a divide (SYSCALL and unknown opcodes included) uses the short pipe.
  function automatic op_class_e op_class(input logic [SIZE_OPCODE_I-1:0] opc);
    case (opc)
      OPC_DIV_L, OPC_DIV_H, OPC_DIVU_L, OPC_DIVU_H: op_class = OP_DIV;
      default:                                      op_class = OP_SHORT;
    endcase
  endfunction

  function automatic logic is_divu(input logic [SIZE_OPCODE_I-1:0] opc);
    is_divu = (opc == OPC_DIVU_L) || (opc == OPC_DIVU_H);
  endfunction

endpackage

// File: rtl/complex_fu_sched_if.sv
// Issue request, complex-ALU drive/return and writeback bundle of the complex unit.
interface complex_fu_sched_if;
  import complex_fu_sched_pkg::*;

  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [SIZE_OPCODE_I-1:0]     req_opcode_i;
  logic [SIZE_DATA-1:0]         req_data1_i;
  logic [SIZE_DATA-1:0]         req_data2_i;
  logic [SIZE_IMMEDIATE-1:0]    req_immd_i;
  logic [SIZE_PHYSICAL_LOG-1:0] req_tag_i;

  logic [SIZE_DATA-1:0]         alu_data1_o;
  logic [SIZE_DATA-1:0]         alu_data2_o;
  logic [SIZE_IMMEDIATE-1:0]    alu_immd_o;
  logic [SIZE_OPCODE_I-1:0]     alu_opcode_o;
  logic [2*SIZE_DATA-1:0]       alu_result_i;
  logic [EXECUTION_FLAGS-1:0]   alu_flags_i;

  logic                         wb_valid_o;
  logic [2*SIZE_DATA-1:0]       wb_result_o;
  logic [EXECUTION_FLAGS-1:0]   wb_flags_o;
  logic [SIZE_PHYSICAL_LOG-1:0] wb_tag_o;

  modport slave (
    input  req_valid_i, req_opcode_i, req_data1_i, req_data2_i, req_immd_i, req_tag_i,
    input  alu_result_i, alu_flags_i,
    output req_ready_o, alu_data1_o, alu_data2_o, alu_immd_o, alu_opcode_o,
    output wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o
  );

  modport master (
    output req_valid_i, req_opcode_i, req_data1_i, req_data2_i, req_immd_i, req_tag_i,
    output alu_result_i, alu_flags_i,
    input  req_ready_o, alu_data1_o, alu_data2_o, alu_immd_o, alu_opcode_o,
    input  wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o
  );

endinterface

// File: rtl/complex_fu_sched_pipe.sv
// complex_fu_pipe: STAGES-deep valid/data shift register for short-latency ops,
// with synchronous clear of the valids (flush) and full reset.
module complex_fu_pipe
  import complex_fu_sched_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  pipe_stage_t in_p0,
  output pipe_stage_t out_pn
);

  pipe_stage_t stg [STAGES];

  // Data advances only behind a valid so the last stage keeps its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0].valid <= in_p0.valid & ~clr;
      if (in_p0.valid) begin
        stg[0].result <= in_p0.result;
        stg[0].flags  <= in_p0.flags;
        stg[0].tag    <= in_p0.tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        stg[i].valid <= stg[i-1].valid & ~clr;
        if (stg[i-1].valid) begin
          stg[i].result <= stg[i-1].result;
          stg[i].flags  <= stg[i-1].flags;
          stg[i].tag    <= stg[i-1].tag;
        end
      end
    end
  end

  assign out_pn = stg[STAGES-1];

endmodule

// File: rtl/complex_fu_sched.sv
// Complex execution unit scheduler: pipelined MULT/SYSCALL path, blocking DIV path,
// in-order writeback and flush. Optional macro COMPLEX_DIV_EARLY_OUT_EN.
module complex_fu_sched
  import complex_fu_sched_pkg::*;
#(
  parameter int DATA_W  = SIZE_DATA,
  parameter int OPC_W   = SIZE_OPCODE_I,
  parameter int TAG_W   = SIZE_PHYSICAL_LOG,
  parameter int FLAG_W  = EXECUTION_FLAGS,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recoverFlag_i,
  complex_fu_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_LAT);

  if (MUL_LAT < 1 || DIV_LAT <= MUL_LAT) begin : g_lat_chk
    $error("complex_fu_sched: need MUL_LAT >= 1 and DIV_LAT > MUL_LAT");
  end
  if (DATA_W != SIZE_DATA || OPC_W != SIZE_OPCODE_I || TAG_W != SIZE_PHYSICAL_LOG ||
      FLAG_W != EXECUTION_FLAGS) begin : g_width_chk
    $error("complex_fu_sched: widths must match complex_fu_sched_pkg");
  end

  sched_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_done_q, div_done_d;
  logic [2*DATA_W-1:0]  div_result_q;
  logic [FLAG_W-1:0]    div_flags_q;
  logic [TAG_W-1:0]     div_tag_q;
  logic                 is_div;
  logic                 accept;
  pipe_stage_t          sh_in_p0, sh_out;

  assign bus.alu_data1_o  = bus.req_data1_i;
  assign bus.alu_data2_o  = bus.req_data2_i;
  assign bus.alu_immd_o   = bus.req_immd_i;
  assign bus.alu_opcode_o = bus.req_opcode_i;

  always_comb begin
    is_div = (op_class(bus.req_opcode_i) == OP_DIV);
`ifdef COMPLEX_DIV_EARLY_OUT_EN
    if (bus.req_data2_i == '0 ||
        (is_divu(bus.req_opcode_i) && bus.req_data1_i < bus.req_data2_i))
      is_div = 1'b0;
`endif
  end

  assign bus.req_ready_o = (state_q == IDLE) & ~recoverFlag_i & ~reset;
  assign accept          = bus.req_valid_i & bus.req_ready_o;

  // Stage p0 input: ALU result sampled in the accept cycle
  always_comb begin
    sh_in_p0.valid  = accept & ~is_div;
    sh_in_p0.result = bus.alu_result_i;
    sh_in_p0.flags  = bus.alu_flags_i;
    sh_in_p0.tag    = bus.req_tag_i;
  end

  complex_fu_pipe #(.STAGES(MUL_LAT)) u_pipe (
    .clk    (clk),
    .rst    (reset),
    .clr    (recoverFlag_i),
    .in_p0  (sh_in_p0),
    .out_pn (sh_out)
  );

  // Divider occupancy: done is raised on the last busy cycle so it lands at t+DIV_LAT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_div) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_W'(DIV_LAT - 1);
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          div_done_d = 1'b1;
          cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (recoverFlag_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      div_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_done_q <= div_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_result_q <= '0;
      div_flags_q  <= '0;
      div_tag_q    <= '0;
    end else if (accept && is_div) begin
      div_result_q <= bus.alu_result_i;
      div_flags_q  <= bus.alu_flags_i;
      div_tag_q    <= bus.req_tag_i;
    end
  end

  // Writeback: div completion and short completion never coincide.
  assign bus.wb_valid_o  = (div_done_q | sh_out.valid) & ~recoverFlag_i & ~reset;
  assign bus.wb_result_o = div_done_q ? div_result_q : sh_out.result;
  assign bus.wb_flags_o  = div_done_q ? div_flags_q  : sh_out.flags;
  assign bus.wb_tag_o    = div_done_q ? div_tag_q    : sh_out.tag;

endmodule

// File: tb/tb_complex_fu_sched.sv
// Scoreboard bench for complex_fu_sched: directed issue vectors push expected
// writebacks (with due cycle); a negedge monitor pops and compares.
module tb_complex_fu_sched;
  import complex_fu_sched_pkg::*;

`ifdef COMPLEX_DIV_EARLY_OUT_EN
  localparam int   EO_LAT = 3;
  localparam logic EO_RDY = 1'b1;
`else
  localparam int   EO_LAT = 16;
  localparam logic EO_RDY = 1'b0;
`endif

  typedef struct {
    logic [6:0]  tag;
    logic [63:0] res;
    logic [5:0]  flags;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic recoverFlag_i;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  complex_fu_sched_if bus();

  complex_fu_sched dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (recoverFlag_i),
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational complex ALU stand-in: div returns {remainder, quotient}.
  logic signed [31:0] sa, sb;
  logic [63:0]        alu_res;
  assign sa = bus.alu_data1_o;
  assign sb = bus.alu_data2_o;
  always_comb begin
    alu_res = '0;
    case (bus.alu_opcode_o)
      OPC_MULT_L, OPC_MULT_H:   alu_res = 64'(sa) * 64'(sb);
      OPC_MULTU_L, OPC_MULTU_H: alu_res = {32'b0, bus.alu_data1_o} * {32'b0, bus.alu_data2_o};
      OPC_DIV_L, OPC_DIV_H:
        if (sb != 0) alu_res = {32'(sa % sb), 32'(sa / sb)};
      OPC_DIVU_L, OPC_DIVU_H:
        if (sb != 0) alu_res = {bus.alu_data1_o % bus.alu_data2_o, bus.alu_data1_o / bus.alu_data2_o};
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_result_i = alu_res;
  assign bus.alu_flags_i  = bus.alu_data1_o[5:0];

  always @(negedge clk) begin
    if (bus.wb_valid_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got tag=%0d result=%h at cycle %0d, required no writeback",
                 bus.wb_tag_o, bus.wb_result_o, cyc);
      end else begin
        mon_e = q.pop_front();
        if (bus.wb_tag_o !== mon_e.tag || bus.wb_result_o !== mon_e.res ||
            bus.wb_flags_o !== mon_e.flags || cyc != mon_e.due) begin
          errors++;
          $display("FAIL wb_tag%0d: got tag=%0d res=%h flags=%h cyc=%0d, required tag=%0d res=%h flags=%h cyc=%0d",
                   mon_e.tag, bus.wb_tag_o, bus.wb_result_o, bus.wb_flags_o, cyc,
                   mon_e.tag, mon_e.res, mon_e.flags, mon_e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      mon_e = q.pop_front();
      $display("FAIL wb_missing: tag=%0d got no writeback by cycle %0d, required at cycle %0d",
               mon_e.tag, cyc, mon_e.due);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Called at a rising edge; returns at the rising edge that accepts the request.
  task automatic issue(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] tag, input logic [63:0] exp_res, input int lat,
                       input bit push, output int acc);
    exp_t e;
    acc = -1;
    #1;
    bus.req_valid_i  = 1'b1;
    bus.req_opcode_i = opc;
    bus.req_data1_i  = a;
    bus.req_data2_i  = b;
    bus.req_tag_i    = tag;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        acc = cyc;
        if (push) begin
          e.tag = tag; e.res = exp_res; e.flags = a[5:0]; e.due = cyc + lat;
          q.push_back(e);
        end
        @(posedge clk);
        break;
      end
      @(posedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: tag=%0d got no ready in 64 cycles, required accept", tag);
    end
  endtask

  task automatic idle();
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, acc, acc2, m, d;
    reset            = 1'b1;
    recoverFlag_i    = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.req_opcode_i = OPC_MULT_L;
    bus.req_data1_i  = 32'd7;
    bus.req_data2_i  = 32'hFFFF_FFFD;
    bus.req_immd_i   = 16'hA5A5;
    bus.req_tag_i    = 7'd0;

    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {63'b0, bus.req_ready_o}, 64'd0);
      chk("rst_wb_valid", {63'b0, bus.wb_valid_o}, 64'd0);
      @(posedge clk);
    end
    #1 reset = 1'b0;
    r = cyc;
    chk("rst_wb_result", bus.wb_result_o, 64'd0);
    chk("rst_wb_tag", {57'b0, bus.wb_tag_o}, 64'd0);
    chk("alu_immd_pass", {48'b0, bus.alu_immd_o}, 64'hA5A5);
    chk("alu_data2_pass", {32'b0, bus.alu_data2_o}, 64'hFFFF_FFFD);

    // Pipelined short ops, back to back
    issue(OPC_MULT_L, 32'd7, 32'hFFFF_FFFD, 7'd5, 64'hFFFF_FFFF_FFFF_FFEB, 3, 1, acc);
    chk("first_accept_cycle", 64'(acc), 64'(r));
    issue(OPC_MULTU_L, 32'hFFFF_FFFF, 32'd2, 7'd6, 64'h0000_0001_FFFF_FFFE, 3, 1, acc);
    chk("b2b_accept_cycle", 64'(acc), 64'(r + 1));
    issue(OPC_MULT_L, 32'd7, 32'hFFFF_FFFD, 7'd7, 64'hFFFF_FFFF_FFFF_FFEB, 3, 1, acc);
    issue(OPC_SYSCALL, 32'd5, 32'd0, 7'd11, 64'd0, 3, 1, acc);
    issue(8'hFF, 32'd9, 32'd1, 7'd13, 64'd0, 3, 1, acc);
    idle();
    drain();

    // Blocking divide, then a multiply accepted on the completion cycle
    issue(OPC_DIVU_L, 32'd100, 32'd7, 7'd9, 64'h0000_0002_0000_000E, 16, 1, t);
    #1 bus.req_valid_i = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk("div_busy_ready", {63'b0, bus.req_ready_o}, 64'd0);
      @(posedge clk);
    end
    issue(OPC_MULT_H, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 7'd14, 64'd20, 3, 1, acc);
    chk("mult_after_div_cycle", 64'(acc), 64'(t + 16));
    idle();
    drain();

    // Mixed order: short then two divides
    issue(OPC_MULT_L, 32'd6, 32'd7, 7'd1, 64'd42, 3, 1, acc);
    issue(OPC_DIVU_H, 32'd50, 32'd5, 7'd2, 64'd10, 16, 1, acc);
    issue(OPC_DIV_L, 32'hFFFF_FFEC, 32'd6, 7'd12, 64'hFFFF_FFFE_FFFF_FFFD, 16, 1, acc2);
    chk("div_b2b_accept_cycle", 64'(acc2), 64'(acc + 16));
    idle();
    drain();

    // Flush: multiply due on the flush cycle, divide in flight, request dropped
    issue(OPC_MULT_L, 32'd2, 32'd3, 7'd3, 64'd0, 3, 0, m);
    issue(OPC_DIV_L, 32'd9, 32'd2, 7'd4, 64'd0, 16, 0, d);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    recoverFlag_i    = 1'b1;
    bus.req_valid_i  = 1'b1;
    bus.req_opcode_i = OPC_MULT_L;
    bus.req_tag_i    = 7'd8;
    @(negedge clk);
    chk("flush_ready", {63'b0, bus.req_ready_o}, 64'd0);
    chk("flush_wb_valid", {63'b0, bus.wb_valid_o}, 64'd0);
    @(posedge clk);
    #1;
    recoverFlag_i   = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", {63'b0, bus.req_ready_o}, 64'd1);
    repeat (24) @(posedge clk);

    // Divide with dividend below divisor
    issue(OPC_DIVU_L, 32'd3, 32'd10, 7'd10, 64'h0000_0003_0000_0000, EO_LAT, 1, acc);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("early_out_ready", {63'b0, bus.req_ready_o}, {63'b0, EO_RDY});
    @(posedge clk);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_fu_sched.md
Name: complex_fu_sched

Overview:
- Issue/sequencing controller for the complex execution unit.
- Accepts issued complex ops (MULT/MULTU/DIV/DIVU/SYSCALL) from the issue queue.
- Drives operands and opcode to the combinational complex ALU and captures its result and flags.
- Models the multiplier as pipelined at MUL_LAT and the divider as blocking at DIV_LAT. Delivers one in-order result per cycle to writeback.
- Kills all in-flight work on branch-mispredict recovery.

Parameters:
- DATA_W, `SIZE_DATA (32): operand width; result is 2*DATA_W.
- OPC_W, `SIZE_OPCODE_I: opcode width.
- TAG_W, `SIZE_PHYSICAL_LOG: destination tag width.
- FLAG_W, `EXECUTION_FLAGS (6): flags width.
- MUL_LAT, 3: multiply/syscall latency, ≥1.
- DIV_LAT, 16: divide latency. Must be > MUL_LAT; elaboration error otherwise.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- recoverFlag_i  in  1  flush all in-flight ops
- req_valid_i  in  1  issue request
- req_ready_o  out  1  unit accepts this cycle
- req_opcode_i  in  OPC_W  op
- req_data1_i  in  DATA_W  operand 1
- req_data2_i  in  DATA_W  operand 2
- req_immd_i  in  `SIZE_IMMEDIATE  immediate, passed to ALU
- req_tag_i  in  TAG_W  destination tag
- alu_data1_o  out  DATA_W  ALU operand 1
- alu_data2_o  out  DATA_W  ALU operand 2
- alu_immd_o  out  `SIZE_IMMEDIATE  ALU immediate
- alu_opcode_o  out  OPC_W  ALU opcode
- alu_result_i  in  2*DATA_W  ALU result
- alu_flags_i  in  FLAG_W  ALU flags
- wb_valid_o  out  1  result valid
- wb_result_o  out  2*DATA_W  result
- wb_flags_o  out  FLAG_W  flags
- wb_tag_o  out  TAG_W  tag

Behaviour:
- Clock and reset:
  - Single clock clk; synchronous active-high reset.
  - While reset is high: req_ready_o=0, wb_valid_o=0.
  - Next cycle: state IDLE, all pipe-stage valids 0, counter 0, wb_result_o/flags/tag 0.
- ALU drive:
  - alu_* outputs = req_* inputs, pass-through and combinational.
  - ALU output is sampled only in the accept cycle.
- Accept:
  - accept = req_valid_i & req_ready_o.
  - req_ready_o = (state==IDLE) & ~recoverFlag_i & ~reset.
- Op classes:
  - DIV_L/DIV_H/DIVU_L/DIVU_H are div.
  - All other opcodes, including SYSCALL and unknown, are short.
- Short path:
  - MUL_LAT-deep shift register of {valid, result, flags, tag}.
  - Stage0 loaded on accept; otherwise stage0.valid=0.
  - Result appears in cycle t+MUL_LAT for accept in cycle t.
  - Back-to-back accepts give back-to-back results.
- Div path FSM, IDLE→DIV_BUSY:
  - On accepting a div op: capture result/flags/tag into the div holding register; load counter = DIV_LAT-1.
  - In DIV_BUSY: counter decrements each cycle. When counter==1, next state is IDLE and the held result is presented (wb_valid) in cycle t+DIV_LAT.
  - req_ready_o is low for cycles t+1 .. t+DIV_LAT-1 and high again in cycle t+DIV_LAT.
- Output mux: wb = div holding register if div is completing, else last short stage.
- No collisions by construction:
  - Older shorts finish ≤ t-1+MUL_LAT < t+DIV_LAT.
  - Newer ops are accepted only at ≥ t+DIV_LAT and finish later.
  - Completion order equals accept order.
- Flush (recoverFlag_i=1 in cycle f):
  - wb_valid_o is forced 0 in cycle f.
  - No accept in cycle f.
  - Next cycle: all stage valids 0, state IDLE, counter 0.
  - Simultaneous with a request: the request is dropped and the issuer must re-issue.
  - Simultaneous with div completion: the result is discarded.
- wb_* data fields hold their last value when wb_valid_o=0 (don't-care for checker).

Optional Feature:
- Macro COMPLEX_DIV_EARLY_OUT_EN.
- Defined:
  - A div op with req_data2_i==0, or a DIVU_L/DIVU_H with req_data1_i < req_data2_i (unsigned), is treated as short.
  - Such an op enters the MUL_LAT pipe; the FSM stays IDLE and ready stays high.
  - Result is still whatever the ALU produced.
- Undefined: all div ops take DIV_LAT.

Decomposition:
- Shared exec package holds:
  - op-class enum {OP_SHORT, OP_DIV};
  - FSM state enum {IDLE, DIV_BUSY};
  - the pipe-stage struct {valid, result, flags, tag};
  - opcode-class decode function.
- One sub-module, complex_fu_pipe: a parameterised MUL_LAT-deep valid/data shift register with synchronous clear.

Test Plan:
- Reset: hold reset 3 cycles with req_valid_i=1 → ready=0 and wb_valid=0 throughout; first accept occurs in the cycle after reset deasserts.
- Pipelined multiply: MULT_L 7×(-3), tags 5,6,7 in cycles 10,11,12 → wb_valid in cycles 13,14,15 with tags 5,6,7; result for tag 5 low word 0xFFFFFFEB.
- Divide: DIVU_L 100/7, tag 9, accepted in cycle 20 → ready=0 in cycles 21–35; wb in cycle 36 with result 14, tag 9; a MULT accepted in cycle 36 returns in cycle 39.
- Mixed order: MULT (tag 1) at cycle 40, then DIV (tag 2) at cycle 41 → tag 1 at cycle 43, tag 2 at cycle 57, never both valid in the same cycle.
- Flush: DIV at cycle 60, MULT in flight, recoverFlag_i at cycle 62 → no wb_valid from cycle 62 onward for either op; ready=1 at cycle 63.
- Early-out (COMPLEX_DIV_EARLY_OUT_EN defined): DIVU_L 3/10 at cycle 70 → wb at cycle 73, ready never drops. Macro undefined → wb at cycle 86.
